// File: rtl/debounce_pkg.sv
// Shared depth defaults and counter sizing for the input-conditioning blocks.
// Counter width covers the larger of the press/release depths without wrapping.
package debounce_pkg;

    localparam int DEFAULT_PRESS_DEPTH   = 15;
    localparam int DEFAULT_RELEASE_DEPTH = 15;
    localparam int DEFAULT_SYNC_STAGES   = 2;

    function automatic int max_depth(input int press_depth, input int release_depth);
        return (press_depth > release_depth) ? press_depth : release_depth;
    endfunction

    function automatic int cnt_width(input int press_depth, input int release_depth);
        return $clog2(max_depth(press_depth, release_depth) + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, run counter, registered level and edge pulses.
// Output changes SYNC_STAGES clocks plus D qualifying strobes after an input edge; no backpressure.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int PRESS_DEPTH   = DEFAULT_PRESS_DEPTH,
    parameter int RELEASE_DEPTH = DEFAULT_RELEASE_DEPTH,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic iclk,
    input  logic iReset,
    input  logic cle_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o,
    output logic busy_o
);

    localparam int CW = cnt_width(PRESS_DEPTH, RELEASE_DEPTH);
    localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_DEPTH - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_DEPTH - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [CW-1:0]          last;
    logic                   q_q;
    logic                   q_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    assign s      = sync_q[SYNC_STAGES-1];
    // Depth is chosen by the direction the output would move to.
    assign last   = s ? PRESS_LAST : RELEASE_LAST;

    always_comb begin
        cnt_d  = cnt_q;
        q_d    = q_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (cle_i) begin
            if (s == q_q) begin
                cnt_d = '0;
            end else if (cnt_q == last) begin
                cnt_d  = '0;
                q_d    = s;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (iReset) begin
            sync_q <= '0;
            cnt_q  <= '0;
            q_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign q_o    = q_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/debounce_bank.sv
// NCH independent debounce channels sharing one sample strobe.
// Outputs registered inside each channel; no backpressure, strobe sets the time base.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int PRESS_DEPTH   = DEFAULT_PRESS_DEPTH,
    parameter int RELEASE_DEPTH = DEFAULT_RELEASE_DEPTH,
    parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
    input  logic           iclk,
    input  logic           iReset,
    input  logic           iCle,
    input  logic [NCH-1:0] ivD,
    output logic [NCH-1:0] ovQ,
    output logic [NCH-1:0] ovRise,
    output logic [NCH-1:0] ovFall,
    output logic [NCH-1:0] ovBusy
);

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        debounce_chan #(
            .PRESS_DEPTH  (PRESS_DEPTH),
            .RELEASE_DEPTH(RELEASE_DEPTH),
            .SYNC_STAGES  (SYNC_STAGES)
        ) u_chan (
            .iclk  (iclk),
            .iReset(iReset),
            .cle_i (iCle),
            .d_i   (ivD[i]),
            .q_o   (ovQ[i]),
            .rise_o(ovRise[i]),
            .fall_o(ovFall[i]),
            .busy_o(ovBusy[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: default, asymmetric-depth and depth-1 instances.
module tb_debounce_bank;

    localparam int NCH  = 4;
    localparam int PD   = 15;
    localparam int RD   = 15;
    localparam int SYNC = 2;

    logic iclk = 1'b0;
    logic rst;

    logic           cle_m;
    logic [NCH-1:0] d_m, q_m, rise_m, fall_m, busy_m;
    logic           cle_a;
    logic [0:0]     d_a, q_a, rise_a, fall_a, busy_a;
    logic           cle_1;
    logic [1:0]     d_1, q_1, rise_1, fall_1, busy_1;

    always #5 iclk = ~iclk;

    debounce_bank #(.NCH(NCH), .PRESS_DEPTH(PD), .RELEASE_DEPTH(RD), .SYNC_STAGES(SYNC)) dut (
        .iclk(iclk), .iReset(rst), .iCle(cle_m), .ivD(d_m),
        .ovQ(q_m), .ovRise(rise_m), .ovFall(fall_m), .ovBusy(busy_m));

    debounce_bank #(.NCH(1), .PRESS_DEPTH(3), .RELEASE_DEPTH(8), .SYNC_STAGES(2)) dut_a (
        .iclk(iclk), .iReset(rst), .iCle(cle_a), .ivD(d_a),
        .ovQ(q_a), .ovRise(rise_a), .ovFall(fall_a), .ovBusy(busy_a));

    debounce_bank #(.NCH(2), .PRESS_DEPTH(1), .RELEASE_DEPTH(1), .SYNC_STAGES(2)) dut_1 (
        .iclk(iclk), .iReset(rst), .iCle(cle_1), .ivD(d_1),
        .ovQ(q_1), .ovRise(rise_1), .ovFall(fall_1), .ovBusy(busy_1));

    int n_chk  = 0;
    int n_pass = 0;
    int rise0_cnt = 0;
    int fall_a_cnt = 0;

    // Reference for the default instance: a log of every strobe sample, and per channel
    // the log index where its current run window opened (last output change or reset).
    logic [NCH-1:0] pipe[$];
    logic [NCH-1:0] slog[$];
    int             since[NCH];
    logic [NCH-1:0] mq, mrise, mfall;

    typedef struct {
        logic       cle;
        logic [1:0] d;
        logic [1:0] q;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;
    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int trail(input int ch, input logic qv);
        int r;
        r = 0;
        for (int j = slog.size() - 1; j >= since[ch]; j--) begin
            if (slog[j][ch] != qv) r++;
            else break;
        end
        return r;
    endfunction

    task automatic model_update();
        logic [NCH-1:0] s;
        int depth;
        if (rst) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back('0);
            slog.delete();
            for (int ch = 0; ch < NCH; ch++) since[ch] = 0;
            mq = '0; mrise = '0; mfall = '0;
        end else begin
            s = pipe.pop_front();
            pipe.push_back(d_m);
            mrise = '0; mfall = '0;
            if (cle_m) begin
                slog.push_back(s);
                for (int ch = 0; ch < NCH; ch++) begin
                    depth = mq[ch] ? RD : PD;
                    if (trail(ch, mq[ch]) >= depth) begin
                        mq[ch] = ~mq[ch];
                        if (mq[ch]) mrise[ch] = 1'b1;
                        else        mfall[ch] = 1'b1;
                        since[ch] = slog.size();
                    end
                end
            end
        end
    endtask

    task automatic tick(input int n);
        logic [NCH-1:0] mb;
        repeat (n) begin
            @(posedge iclk);
            model_update();
            #1;
            for (int ch = 0; ch < NCH; ch++) mb[ch] = (trail(ch, mq[ch]) > 0);
            chk("model_q", q_m, mq);
            chk("model_rise", rise_m, mrise);
            chk("model_fall", fall_m, mfall);
            chk("model_busy", busy_m, mb);
            if (rise_m[0]) rise0_cnt++;
            if (fall_a[0]) fall_a_cnt++;
        end
    endtask

    task automatic strobe_m();
        cle_m = 1'b1;
        tick(1);
        cle_m = 1'b0;
    endtask

    task automatic strobe_a();
        cle_a = 1'b1;
        tick(1);
        cle_a = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b00};
        tbl[3]  = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
        tbl[4]  = '{1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
        tbl[5]  = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b01};
        tbl[6]  = '{1'b1, 2'b10, 2'b10, 2'b00, 2'b00};
        tbl[7]  = '{1'b1, 2'b00, 2'b10, 2'b00, 2'b00};
        tbl[8]  = '{1'b1, 2'b11, 2'b10, 2'b00, 2'b00};
        tbl[9]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b10};
        tbl[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        tbl[11] = '{1'b1, 2'b00, 2'b11, 2'b11, 2'b00};
        tbl[12] = '{1'b1, 2'b00, 2'b11, 2'b00, 2'b00};
        tbl[13] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b11};

        rst = 1'b1; cle_m = 1'b0; cle_a = 1'b0; cle_1 = 1'b0;
        d_m = 4'hF; d_a = 1'b0; d_1 = 2'b00;
        tick(3);
        chk("reset_q", q_m, 0);
        chk("reset_busy", busy_m, 0);
        chk("reset_rise", rise_m, 0);
        chk("reset_fall", fall_m, 0);
        chk("reset_q_a", q_a, 0);
        chk("reset_q_1", q_1, 0);
        rst = 1'b0;

        // Held high through reset: full press depth needed, strobe every 4 clocks.
        for (int k = 1; k <= 15; k++) begin
            tick(3);
            strobe_m();
            if (k < 15) begin
                chk("rst_hold_q", q_m, 0);
                chk("rst_hold_busy", busy_m, 4'hF);
            end else begin
                chk("rst_rise_q", q_m, 4'hF);
                chk("rst_rise_pulse", rise_m, 4'hF);
                chk("rst_rise_busy", busy_m, 0);
            end
        end
        tick(1);
        chk("rst_rise_width", rise_m, 0);

        for (int r = 0; r < 14; r++) begin
            cle_1 = tbl[r].cle;
            d_1   = tbl[r].d;
            tick(1);
            chk($sformatf("depth1_q_%0d", r), q_1, tbl[r].q);
            chk($sformatf("depth1_rise_%0d", r), rise_1, tbl[r].rise);
            chk($sformatf("depth1_fall_%0d", r), fall_1, tbl[r].fall);
            chk($sformatf("depth1_busy_%0d", r), busy_1, 0);
        end
        cle_1 = 1'b0;

        d_a = 1'b1;
        tick(2);
        for (int k = 1; k <= 3; k++) begin
            strobe_a();
            if (k < 3) chk("asym_press_wait", q_a, 0);
            else begin
                chk("asym_press_q", q_a, 1);
                chk("asym_press_rise", rise_a, 1);
            end
            tick(1);
        end
        fall_a_cnt = 0;
        d_a = 1'b0;
        tick(2);
        for (int k = 1; k <= 8; k++) begin
            strobe_a();
            if (k < 8) begin
                chk("asym_rel_wait", q_a, 1);
                chk("asym_rel_busy", busy_a, 1);
            end else begin
                chk("asym_rel_q", q_a, 0);
                chk("asym_rel_fall", fall_a, 1);
            end
        end
        tick(2);
        chk("asym_fall_count", fall_a_cnt, 1);

        d_m = 4'h0;
        tick(2);
        repeat (15) strobe_m();
        chk("release_all_q", q_m, 0);

        // Bounce on ch0 never accumulates a full run.
        rise0_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            d_m[0] = (k % 2 == 0);
            tick(2);
            strobe_m();
            chk("bounce_q0", q_m[0], 0);
        end
        d_m[0] = 1'b1;
        tick(2);
        for (int k = 1; k <= 15; k++) begin
            strobe_m();
            if (k < 15) chk("bounce_hold_q0", q_m[0], 0);
            else        chk("bounce_rise_q0", q_m[0], 1);
        end
        tick(1);
        chk("bounce_rise_count", rise0_cnt, 1);

        d_m[2] = 1'b1;
        tick(2);
        repeat (14) strobe_m();
        chk("glitch_pre_q2", q_m[2], 0);
        chk("glitch_pre_busy2", busy_m[2], 1);
        d_m[2] = 1'b0;
        tick(2);
        strobe_m();
        chk("glitch_busy2", busy_m[2], 0);
        d_m[2] = 1'b1;
        tick(2);
        for (int k = 1; k <= 15; k++) begin
            strobe_m();
            if (k == 14) chk("glitch_wait_q2", q_m[2], 0);
            if (k == 15) begin
                chk("glitch_rise_q2", q_m[2], 1);
                chk("glitch_rise_vec", rise_m, 4'b0100);
            end
        end

        d_m[3] = 1'b1;
        tick(2);
        repeat (15) strobe_m();
        chk("simul_setup_q", q_m, 4'b1101);
        d_m[1] = 1'b1;
        d_m[3] = 1'b0;
        tick(2);
        for (int k = 1; k <= 15; k++) begin
            strobe_m();
            if (k == 14) chk("simul_wait_q", q_m, 4'b1101);
            if (k == 15) begin
                chk("simul_q", q_m, 4'b0111);
                chk("simul_rise", rise_m, 4'b0010);
                chk("simul_fall", fall_m, 4'b1000);
            end
        end

        d_m[0] = 1'b0;
        tick(2);
        repeat (15) strobe_m();
        chk("midrst_setup_q", q_m, 4'b0110);
        d_m[0] = 1'b1;
        tick(2);
        repeat (10) strobe_m();
        chk("midrst_busy0", busy_m[0], 1);
        rst = 1'b1;
        cle_m = 1'b1;
        tick(2);
        rst = 1'b0;
        cle_m = 1'b0;
        chk("midrst_q", q_m, 0);
        chk("midrst_busy", busy_m, 0);
        tick(2);
        for (int k = 1; k <= 15; k++) begin
            strobe_m();
            if (k == 14) chk("midrst_wait_q0", q_m[0], 0);
            if (k == 15) chk("midrst_rise_q", q_m, 4'b0111);
        end

        // Strobe tied high: sync delay then RELEASE_DEPTH consecutive clocks.
        d_m = 4'h0;
        cle_m = 1'b1;
        tick(16);
        chk("tied_wait_q", q_m, 4'b0111);
        tick(1);
        chk("tied_q", q_m, 0);
        chk("tied_fall", fall_m, 4'b0111);
        cle_m = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 47) == 0) d_m[ch] = ~d_m[ch];
            cle_m = ($urandom_range(0, 2) != 0);
            rst   = ($urandom_range(0, 1499) == 0);
            tick(1);
        end
        rst = 1'b0;
        cle_m = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for mechanical inputs (buttons, switches, reed contacts) feeding the spirometer control logic. Each channel synchronises its raw input, then requires a configurable run of consecutive agreeing samples before its clean output changes, in both directions, with separate press and release depths. It also emits one-cycle rise/fall pulses, so downstream FSMs need no edge detectors of their own. A shared sample strobe sets the debounce time base.

## Interface
Parameters:
- NCH, 4, number of independent channels (≥1)
- PRESS_DEPTH, 15, consecutive high samples required to drive a channel output 0→1 (≥1)
- RELEASE_DEPTH, 15, consecutive low samples required to drive a channel output 1→0 (≥1)
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)

Ports:
- iclk  in  1  clock
- iReset  in  1  reset, synchronous, active-high
- iCle  in  1  sample strobe; one-cycle pulse from the system tick divider
- ivD  in  NCH  raw asynchronous inputs
- ovQ  out  NCH  debounced levels
- ovRise  out  NCH  one-cycle pulse when ovQ[i] goes 0→1
- ovFall  out  NCH  one-cycle pulse when ovQ[i] goes 1→0
- ovBusy  out  NCH  high while channel i has a nonzero run counter (candidate change pending)

## Operation
- Synchroniser: each ivD[i] passes through SYNC_STAGES flops clocked every iclk, independent of iCle; s[i] is the last stage.
- Run counter cnt[i], width CW = clog2(max(PRESS_DEPTH, RELEASE_DEPTH)+1), unsigned, never wraps.
- On a cycle with iCle=1, per channel:
  - s[i]==ovQ[i]: cnt[i]←0.
  - s[i]!=ovQ[i], target depth D = PRESS_DEPTH if s[i]=1 else RELEASE_DEPTH:
    - cnt[i]==D−1: ovQ[i]←s[i]; cnt[i]←0; the matching ovRise[i]/ovFall[i]←1.
    - else cnt[i]←cnt[i]+1.
- On iCle=0 cycles: cnt and ovQ hold; ovRise/ovFall←0.
- A single disagreeing sample mid-run restarts the run from zero. There is no partial credit.
- ovBusy[i] = (cnt[i]!=0), combinational from the register.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Depth 1 means the output follows s[i] on the next iCle.

## Timing
- Reset: synchroniser flops, cnt, ovQ, ovRise, ovFall all 0. ovBusy therefore 0.
- iReset has priority over iCle. Reset asserted mid-run discards the run. A channel held high through reset needs the full PRESS_DEPTH strobes after reset release to reach ovQ=1.
- Latency: an ivD edge is visible at s[i] after SYNC_STAGES clock edges. ovQ then changes on the clock edge of the D-th qualifying iCle counted from the first strobe that samples the new s[i].
- ovRise/ovFall are high for exactly one iclk, registered, and coincide with the first cycle ovQ shows the new level.
- iCle held high continuously is legal. Debounce then completes in D consecutive clocks.
- ovQ/ovRise/ovFall are all registered. No combinational path from ivD or iCle to any output except through flops.

## Structure
- Package debounce_pkg holds the counter-width function (clog2 of max depth + 1) and the default depth constants. Other input-conditioning blocks share them.
- One sub-module, debounce_chan: synchroniser, run counter, output/pulse flops for one channel, with PRESS_DEPTH/RELEASE_DEPTH/SYNC_STAGES passed through.
- debounce_bank generates NCH instances and concatenates their outputs.

## Test plan
- Reset: drive ivD=4'hF during reset, release, and pulse iCle every 4 clocks. ovQ=0 until the 15th strobe. On that strobe's edge, ovQ=4'hF and ovRise=4'hF for one cycle. ovBusy was 4'hF from the 1st strobe onward.
- Bounce: ch0 toggles 1/0 on alternate strobes for 20 strobes, then holds 1. ovQ[0] stays 0 and rises exactly 15 strobes after the hold begins. One ovRise[0] pulse in total.
- Asymmetric depth (PRESS_DEPTH=3, RELEASE_DEPTH=8): a press sets ovQ after 3 strobes. The release clears ovQ after 8 strobes, with one ovFall pulse.
- Glitch reset: ch2 high for 14 strobes, low for 1, high again. The rise occurs 15 strobes after the re-high, not after 1.
- Simultaneous channels: ch1 rises while ch3 falls, on identical strobes. ovRise[1] and ovFall[3] assert in the same cycle, and other bits stay 0.
- Reset mid-run: assert iReset with cnt[0]=10. After release, ovQ[0]=0, ovBusy[0]=0, and the full 15 strobes are required again. Also cover iCle tied high and depth 1.
